rom_image_loader: RTL and testbench
===================================

# rom_image_loader

Streams a byte-wide ROM image, already loaded into the simulation/boot byte RAM from the ROMFILE plusarg, into the Phaethon core memory as 32-bit little-endian words. It sits directly downstream of the image RAM: it drives its synchronous read port and emits a write request stream on a valid/ready handshake toward the memory controller. Partial final words are written with a byte mask. It reports busy/done so the boot sequencer can release the core.

## Interface
- ADDR_W, 16, byte-address width of the image RAM (image holds up to 2^ADDR_W bytes)
- BASE_ADDR, 32'h0, core byte address that receives image byte 0 (must be 4-byte aligned)

- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a load; sampled only in IDLE
- image_len  in  ADDR_W+1  number of bytes to load, latched on accepted start
- rd_en  out  1  image RAM read enable
- rd_addr  out  ADDR_W  image RAM byte address
- rd_data  in  8  image RAM read data, valid the cycle after rd_en
- mem_wr_valid  out  1  write request valid
- mem_wr_ready  in  1  memory controller accepts request when high with valid
- mem_wr_addr  out  32  word-aligned core byte address
- mem_wr_data  out  32  little-endian word (image byte 4n at bits 7:0)
- mem_wr_mask  out  4  byte enables; bit i covers bits 8i+7:8i
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of load

## Operation
- States: IDLE, RD, LAST, WR, DONE.
- IDLE: on start, latch image_len; if 0 go DONE, else clear byte index and word index, go RD.
- RD: assert rd_en, rd_addr = byte index; capture rd_data from previous RD cycle into lane (index−1) mod 4; increment byte index. Remain in RD until 4 bytes of the word are issued or byte index reaches image_len, then go LAST.
- LAST: capture final byte of the word; go WR. rd_en low.
- WR: hold mem_wr_valid, addr, data, mask stable until mem_wr_ready. On handshake: increment word index; if byte index == image_len go DONE, else clear lanes, go RD.
- DONE: done = 1 for exactly one cycle, go IDLE.
- mem_wr_addr = BASE_ADDR + 4·word index, modulo 2^32.
- Mask: 4'b1111 for full words; final partial word of k bytes gives mask with low k bits set, unused data lanes = 0.
- start while busy is ignored; image_len changes while busy have no effect.
- reset in any state: return to IDLE immediately, abandoning any pending write (valid drops next cycle).

## Timing
- Reset values: rd_en 0, rd_addr 0, mem_wr_valid 0, mem_wr_addr 0, mem_wr_data 0, mem_wr_mask 0, busy 0, done 0.
- start in cycle 0 → RD cycles 1–4 (rd_addr 0..3) → LAST cycle 5 → mem_wr_valid first high cycle 6.
- Full word with ready held high: 6 cycles per word (4 RD + LAST + WR); partial word of k bytes: k+2 cycles.
- done pulses the cycle after the final handshake; busy falls with done's cycle ending (low the cycle after done).
- image_len = 0: done in cycle 1, no rd_en, no writes.
- image_len = 2^ADDR_W: rd_addr wraps to 0 only after completion; last address issued is 2^ADDR_W−1.
- Outputs are registered; no combinational path from mem_wr_ready to any output.

## Structure
- Package phaethon_boot_pkg: loader state enum, WORD_BYTES = 4, mask-from-count function.
- One sub-module natural: loader_word_packer (lane capture, zero-fill, mask generation), instantiated once.
- Top holds FSM, counters, handshake register.

## Test plan
- image_len 8, bytes 00..07, ready high → two writes: addr 0 data 32'h03020100 mask F; addr 4 data 32'h07060504 mask F; done at cycle 13.
- image_len 6, BASE_ADDR 32'h1000 → writes 32'h03020100@1000 mask F, 32'h00000504@1004 mask 3.
- image_len 4, ready low for 5 cycles in WR → valid/addr/data/mask stable all 5 cycles; single acceptance; done next cycle.
- image_len 0 → done pulse cycle 1, zero rd_en and valid cycles; start during busy ignored (no second load).
- reset asserted in WR mid-load with valid high → valid 0 and busy 0 the next cycle; fresh start reloads from addr BASE_ADDR.

Source files
------------

// File: rtl/phaethon_boot_pkg.sv
// Shared types and helpers for the Phaethon boot path: loader state encoding,
// word geometry and byte-enable generation for partial words.
package phaethon_boot_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LAST,
        WR,
        DONE
    } loaderState_t;

    // Low 'count' bits set; count saturates naturally at WORD_BYTES.
    function automatic logic [WORD_BYTES-1:0] maskFromCount(input logic [2:0] count);
        logic [WORD_BYTES-1:0] mask;
        mask = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (3'(i) < count) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Assembles image bytes into a little-endian 32-bit word, tracking how many
// lanes were filled so the final partial word gets the right byte mask.
module loader_word_packer
    import phaethon_boot_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  capture,
    input  logic [1:0]            lane,
    input  logic [7:0]            byteIn,
    output logic [31:0]           wordData,
    output logic [WORD_BYTES-1:0] wordMask
);

    logic [2:0] byteCount;

    // Clearing zeroes every lane so unused lanes of a partial word read as 0.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wordData  <= '0;
            byteCount <= '0;
        end else if (capture) begin
            wordData[{lane, 3'b000} +: 8] <= byteIn;
            byteCount                    <= byteCount + 3'd1;
        end
    end

    assign wordMask = maskFromCount(byteCount);

endmodule

// File: rtl/rom_image_loader.sv
// Streams a byte-wide ROM image out of the boot image RAM into core memory as
// 32-bit little-endian word writes on a valid/ready handshake.
module rom_image_loader
    import phaethon_boot_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   image_len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [31:0]       mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic [3:0]        mem_wr_mask,
    output logic              busy,
    output logic              done
);

    loaderState_t    state;
    loaderState_t    nextState;
    logic [ADDR_W:0] byteIdx;
    logic [ADDR_W:0] byteIdxNext;
    logic [ADDR_W:0] lenReg;
    logic [31:0]     wordAddr;
    logic            rdValid;
    logic            startAccept;
    logic            handshake;
    logic            wordEnd;

    assign startAccept = (state == IDLE) && start;
    assign handshake   = (state == WR) && mem_wr_ready;
    assign byteIdxNext = byteIdx + (ADDR_W + 1)'(1);
    assign wordEnd     = (byteIdxNext == lenReg) || (byteIdxNext[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = (image_len == '0) ? DONE : RD;
                end
            end
            RD: begin
                if (wordEnd) begin
                    nextState = LAST;
                end
            end
            LAST: nextState = WR;
            WR: begin
                if (mem_wr_ready) begin
                    nextState = (byteIdx == lenReg) ? DONE : RD;
                end
            end
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        rd_en        = 1'b0;
        mem_wr_valid = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (state)
            IDLE: busy = 1'b0;
            RD:   rd_en = 1'b1;
            WR:   mem_wr_valid = 1'b1;
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    // rdValid marks the cycle a RAM byte is on rd_data; the word address
    // register stands in for BASE_ADDR + 4 * word index.
    always_ff @(posedge clk) begin
        if (reset) begin
            byteIdx  <= '0;
            lenReg   <= '0;
            wordAddr <= '0;
            rdValid  <= 1'b0;
        end else begin
            rdValid <= (state == RD);
            if (startAccept) begin
                lenReg   <= image_len;
                byteIdx  <= '0;
                wordAddr <= BASE_ADDR;
            end
            if (state == RD) begin
                byteIdx <= byteIdxNext;
            end
            if (handshake) begin
                wordAddr <= wordAddr + 32'd4;
            end
        end
    end

    loader_word_packer packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (startAccept || handshake),
        .capture  (rdValid),
        .lane     (byteIdx[1:0] - 2'd1),
        .byteIn   (rd_data),
        .wordData (mem_wr_data),
        .wordMask (mem_wr_mask)
    );

    assign rd_addr     = byteIdx[ADDR_W-1:0];
    assign mem_wr_addr = wordAddr;

endmodule

// File: tb/tb_rom_image_loader.sv
// Self-checking bench for rom_image_loader: a byte-RAM model feeds the loader and
// a write scoreboard built from the image contents checks every accepted word.
module tb_rom_image_loader;

    localparam int          ADDR_W   = 4;
    localparam int          IMG_SIZE = 1 << ADDR_W;
    localparam logic [31:0] BASE     = 32'h0000_1000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   image_len;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data = 8'h00;
    logic              mem_wr_valid;
    logic              mem_wr_ready = 1'b1;
    logic [31:0]       mem_wr_addr;
    logic [31:0]       mem_wr_data;
    logic [3:0]        mem_wr_mask;
    logic              busy;
    logic              done;

    int  checks = 0;
    int  failures = 0;
    int  stallBudget = 0;
    int  stallUsed = 0;
    wr_t expQ[$];
    wr_t obsQ[$];
    logic [7:0] imageMem [0:IMG_SIZE-1];

    always #5 clk = ~clk;

    rom_image_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .image_len    (image_len),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_ready (mem_wr_ready),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_mask  (mem_wr_mask),
        .busy         (busy),
        .done         (done)
    );

    always @(posedge clk) begin
        if (rd_en) rd_data <= imageMem[rd_addr];
    end

    // Memory controller: refuses the first stallBudget cycles of each request.
    always @(posedge clk) begin
        #1;
        if (mem_wr_valid && stallUsed < stallBudget) begin
            mem_wr_ready = 1'b0;
            stallUsed++;
        end else begin
            mem_wr_ready = 1'b1;
            if (!mem_wr_valid) stallUsed = 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Expected writes straight from the image bytes: word n covers bytes 4n..4n+3.
    task automatic buildModel(input int len);
        wr_t w;
        expQ.delete();
        for (int b = 0; b < len; b += 4) begin
            w.addr = BASE + 32'(b);
            w.data = '0;
            w.mask = '0;
            for (int j = 0; j < 4 && b + j < len; j++) begin
                w.data[8*j +: 8] = imageMem[b + j];
                w.mask[j]        = 1'b1;
            end
            expQ.push_back(w);
        end
    endtask

    logic prevValid = 1'b0;
    logic prevReady = 1'b0;
    wr_t  held;

    always @(negedge clk) begin
        wr_t e;
        if (mem_wr_valid && prevValid && !prevReady) begin
            checkOutput("holdAddr", mem_wr_addr, held.addr);
            checkOutput("holdData", mem_wr_data, held.data);
            checkOutput("holdMask", 32'(mem_wr_mask), 32'(held.mask));
        end
        if (mem_wr_valid && mem_wr_ready) begin
            obsQ.push_back('{mem_wr_addr, mem_wr_data, mem_wr_mask});
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWrite", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("wrAddr", mem_wr_addr, e.addr);
                checkOutput("wrData", mem_wr_data, e.data);
                checkOutput("wrMask", 32'(mem_wr_mask), 32'(e.mask));
            end
        end
        prevValid = mem_wr_valid;
        prevReady = mem_wr_ready;
        held      = '{mem_wr_addr, mem_wr_data, mem_wr_mask};
    end

    // One complete load; cycle 0 is the cycle start is high.
    task automatic applyStimulus(input string name, input int len, input int stall,
                                 input int expDone, input int pokeAt);
        int doneCycle;
        int rdCount;
        int maxAddr;
        buildModel(len);
        obsQ.delete();
        stallBudget = stall;
        @(posedge clk); #1;
        image_len = (ADDR_W + 1)'(len);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        doneCycle = -1;
        rdCount   = 0;
        maxAddr   = -1;
        for (int cyc = 1; cyc < 300; cyc++) begin
            @(negedge clk);
            if (rd_en) begin
                rdCount++;
                if (int'(rd_addr) > maxAddr) maxAddr = int'(rd_addr);
            end
            if (cyc == 1) checkOutput({name, ".busyEarly"}, 32'(busy), 32'd1);
            if (done && doneCycle < 0) doneCycle = cyc;
            if (pokeAt > 0 && cyc == pokeAt) begin
                start     = 1'b1;
                image_len = (ADDR_W + 1)'(12);
            end
            if (pokeAt > 0 && cyc == pokeAt + 1) start = 1'b0;
            if (doneCycle >= 0 && cyc == doneCycle + 1) begin
                checkOutput({name, ".busyAfterDone"}, 32'(busy), 32'd0);
                checkOutput({name, ".donePulse"}, 32'(done), 32'd0);
                checkOutput({name, ".rdAddrEnd"}, 32'(rd_addr), 32'(len % IMG_SIZE));
                break;
            end
        end
        checkOutput({name, ".doneCycle"}, 32'(doneCycle), 32'(expDone));
        checkOutput({name, ".rdCount"}, 32'(rdCount), 32'(len));
        checkOutput({name, ".lastRdAddr"}, 32'(maxAddr), 32'(len - 1));
        checkOutput({name, ".writesLeft"}, 32'(expQ.size()), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput({name, ".idle"}, 32'(busy), 32'd0);
        end
        stallBudget = 0;
    endtask

    task automatic applyResetMidWrite();
        bit sawValid;
        buildModel(8);
        stallBudget = 10;
        @(posedge clk); #1;
        image_len = (ADDR_W + 1)'(8);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        sawValid  = 1'b0;
        for (int cyc = 1; cyc < 40; cyc++) begin
            @(negedge clk);
            if (mem_wr_valid) begin
                sawValid = 1'b1;
                reset    = 1'b1;
                break;
            end
        end
        checkOutput("rst.sawValid", 32'(sawValid), 32'd1);
        @(negedge clk);
        checkOutput("rst.valid", 32'(mem_wr_valid), 32'd0);
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.rdEn", 32'(rd_en), 32'd0);
        reset = 1'b0;
        expQ.delete();
        stallBudget = 0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        image_len = '0;
        for (int i = 0; i < IMG_SIZE; i++) imageMem[i] = 8'(i);
        repeat (3) @(negedge clk);
        checkOutput("reset.rdEn", 32'(rd_en), 32'd0);
        checkOutput("reset.rdAddr", 32'(rd_addr), 32'd0);
        checkOutput("reset.valid", 32'(mem_wr_valid), 32'd0);
        checkOutput("reset.addr", mem_wr_addr, 32'd0);
        checkOutput("reset.data", mem_wr_data, 32'd0);
        checkOutput("reset.mask", 32'(mem_wr_mask), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        applyStimulus("len8", 8, 0, 13, 0);
        checkOutput("len8.count", 32'(obsQ.size()), 32'd2);
        if (obsQ.size() >= 2) begin
            checkOutput("len8.w0addr", obsQ[0].addr, 32'h0000_1000);
            checkOutput("len8.w0data", obsQ[0].data, 32'h0302_0100);
            checkOutput("len8.w0mask", 32'(obsQ[0].mask), 32'hF);
            checkOutput("len8.w1data", obsQ[1].data, 32'h0706_0504);
        end

        applyStimulus("len6", 6, 0, 11, 3);
        checkOutput("len6.count", 32'(obsQ.size()), 32'd2);
        if (obsQ.size() >= 2) begin
            checkOutput("len6.w1addr", obsQ[1].addr, 32'h0000_1004);
            checkOutput("len6.w1data", obsQ[1].data, 32'h0000_0504);
            checkOutput("len6.w1mask", 32'(obsQ[1].mask), 32'h3);
        end

        applyStimulus("len4stall", 4, 5, 12, 0);
        checkOutput("len4stall.count", 32'(obsQ.size()), 32'd1);

        applyStimulus("len0", 0, 0, 1, 1);
        checkOutput("len0.count", 32'(obsQ.size()), 32'd0);

        applyStimulus("len5", 5, 0, 10, 0);
        if (obsQ.size() >= 2) begin
            checkOutput("len5.w1data", obsQ[1].data, 32'h0000_0004);
            checkOutput("len5.w1mask", 32'(obsQ[1].mask), 32'h1);
        end

        for (int i = 0; i < IMG_SIZE; i++) imageMem[i] = 8'(255 - 13 * i);
        applyStimulus("full", IMG_SIZE, 0, 25, 0);
        if (obsQ.size() >= 4) begin
            checkOutput("full.w3addr", obsQ[3].addr, 32'h0000_100C);
        end

        applyResetMidWrite();
        applyStimulus("reload", 8, 0, 13, 0);
        if (obsQ.size() >= 1) begin
            checkOutput("reload.w0addr", obsQ[0].addr, BASE);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
